// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx line, mid-bit sampling,
// optional parity, one-cycle valid/frame/parity/break strobes.
module uart_rx #(
  parameter int FREQ_HZ = 50000000,
  parameter int BAUDS   = 115200,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       break_o
);

  localparam int CLKS_PER_BIT = FREQ_HZ / BAUDS;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          ODD     = (PARITY == 2);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [1:0]    prime_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          pbit_q, pbit_d;
  logic          perr_q, perr_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;
  logic          brk_q, brk_d;
  logic          tick;

  // prime_q keeps the synchroniser's reset value from counting as idle
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    brk_d   = 1'b0;
    unique case (state_q)
      S_WAIT_IDLE: begin
        if (prime_q[1] && rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!rx_s_q) begin
          bit_d   = 3'd0;
          cnt_d   = HALF_LD;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = BIT_LD;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = BIT_LD;
          if (bit_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          pbit_d  = rx_s_q;
          perr_d  = ((^shift_q) ^ rx_s_q) != ODD;
          cnt_d   = BIT_LD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s_q) begin
          if (perr_q) begin
            pe_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
          state_d = S_IDLE;
        end else begin
          fe_d    = 1'b1;
          pe_d    = perr_q;
          brk_d   = (shift_q == 8'h00) && !pbit_q;
          state_d = S_WAIT_IDLE;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_WAIT_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      brk_q   <= brk_d;
    end
  end

  assign rx_data_o    = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = fe_q;
  assign parity_err_o = pe_q;
  assign break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed table, hand corner cases and
// random frames against a frame-level model, three parity modes.
module tb_uart_rx;

  localparam int FREQ = 1000000;
  localparam int BAUD = 100000;
  localparam int CPB  = 10;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] dat[3];
  logic       v[3], fe[3], pe[3], br[3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic       v, fe, pe, br;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic       ev_v;
    logic       ev_fe;
    logic [7:0] ev_d;
  } vec_t;

  ev_t q0[$], q1[$], q2[$];

  uart_rx #(.FREQ_HZ(FREQ), .BAUDS(BAUD), .PARITY(0)) u_p0 (
    .clk(clk), .reset_ni(reset_ni), .rx_i(rx_i),
    .rx_data_o(dat[0]), .valid_o(v[0]), .frame_err_o(fe[0]),
    .parity_err_o(pe[0]), .break_o(br[0])
  );
  uart_rx #(.FREQ_HZ(FREQ), .BAUDS(BAUD), .PARITY(1)) u_p1 (
    .clk(clk), .reset_ni(reset_ni), .rx_i(rx_i),
    .rx_data_o(dat[1]), .valid_o(v[1]), .frame_err_o(fe[1]),
    .parity_err_o(pe[1]), .break_o(br[1])
  );
  uart_rx #(.FREQ_HZ(FREQ), .BAUDS(BAUD), .PARITY(2)) u_p2 (
    .clk(clk), .reset_ni(reset_ni), .rx_i(rx_i),
    .rx_data_o(dat[2]), .valid_o(v[2]), .frame_err_o(fe[2]),
    .parity_err_o(pe[2]), .break_o(br[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i] | fe[i] | pe[i] | br[i]) begin
        ev_t e;
        e.c = cyc; e.v = v[i]; e.fe = fe[i];
        e.pe = pe[i]; e.br = br[i]; e.d = dat[i];
        case (i)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  end

  function automatic ev_t model(input int mode, input logic [7:0] d,
                                input logic p, input logic stop,
                                input logic [7:0] last, input int c);
    ev_t e;
    bit odd_total, mism;
    odd_total = (($countones(d) + int'(p)) % 2) == 1;
    mism = (mode != 0) && (odd_total != (mode == 2));
    e.c = c; e.v = 0; e.fe = 0; e.pe = 0; e.br = 0;
    if (stop) begin
      if (mism) e.pe = 1;
      else e.v = 1;
    end else begin
      e.fe = 1;
      e.pe = mism;
      e.br = (d == 8'h00) && (mode == 0 || p == 1'b0);
    end
    e.d = e.v ? d : last;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input string name, input int inst, input ev_t x);
    ev_t e;
    bit ok;
    ok = 0;
    case (inst)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
    endcase
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no pulse seen, expected c=%0d v=%b fe=%b pe=%b br=%b d=%h",
               name, x.c, x.v, x.fe, x.pe, x.br, x.d);
    end else if (e.c != x.c || e.v !== x.v || e.fe !== x.fe ||
                 e.pe !== x.pe || e.br !== x.br || e.d !== x.d) begin
      errors++;
      $display("FAIL %s: got c=%0d v=%b fe=%b pe=%b br=%b d=%h expected c=%0d v=%b fe=%b pe=%b br=%b d=%h",
               name, e.c, e.v, e.fe, e.pe, e.br, e.d,
               x.c, x.v, x.fe, x.pe, x.br, x.d);
    end
  endtask

  task automatic expect_none(input string name, input int inst);
    int n;
    case (inst)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s: got %0d extra pulse cycles expected 0", name, n);
    end
    case (inst)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic flush();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic bitw(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit has_p, input logic p,
                      input logic stop, output int t0);
    t0 = cyc;
    bitw(1'b0, CPB);
    for (int i = 0; i < 8; i++) bitw(d[i], CPB);
    if (has_p) bitw(p, CPB);
    bitw(stop, CPB);
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    repeat (10) @(negedge clk);
    flush();
  endtask

  function automatic ev_t mk(input int c, input logic v_, input logic fe_,
                             input logic pe_, input logic br_,
                             input logic [7:0] d_);
    ev_t e;
    e.c = c; e.v = v_; e.fe = fe_; e.pe = pe_; e.br = br_; e.d = d_;
    return e;
  endfunction

  vec_t tbl[6];

  initial begin
    int t0;
    logic [7:0] last0, last1, last2;
    ev_t x;

    tbl[0] = '{8'h55, 1'b1, 0,  1'b1, 1'b0, 8'h55};
    tbl[1] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 10, 1'b1, 1'b0, 8'hFF};
    tbl[3] = '{8'h55, 1'b1, 5,  1'b1, 1'b0, 8'h55};
    tbl[4] = '{8'h3C, 1'b0, 20, 1'b0, 1'b1, 8'h55};
    tbl[5] = '{8'h12, 1'b1, 10, 1'b1, 1'b0, 8'h12};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_outs%0d", i),
          {dat[i], v[i], fe[i], pe[i], br[i]}, 32'h0);
    end
    reset_ni = 1'b1;
    repeat (10) @(negedge clk);
    flush();

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, 0, 1'b0, tbl[i].stop, t0);
      x = mk(t0 + 98, tbl[i].ev_v, tbl[i].ev_fe, 1'b0, 1'b0, tbl[i].ev_d);
      expect_ev($sformatf("tbl%0d_pulse", i), 0, x);
      expect_none($sformatf("tbl%0d_extra", i), 0);
      chk($sformatf("tbl%0d_data", i), dat[0], tbl[i].ev_d);
      bitw(1'b1, tbl[i].gap);
    end
    last0 = 8'h12;

    bitw(1'b0, 3);
    bitw(1'b1, 30);
    expect_none("glitch", 0);
    send(8'hA3, 0, 1'b0, 1'b1, t0);
    expect_ev("after_glitch", 0, mk(t0 + 98, 1, 0, 0, 0, 8'hA3));
    expect_none("after_glitch_extra", 0);
    bitw(1'b1, 5);

    t0 = cyc;
    bitw(1'b0, 15 * CPB);
    expect_ev("break", 0, mk(t0 + 98, 0, 1, 0, 1, 8'hA3));
    expect_none("break_extra", 0);
    bitw(1'b1, 20);
    send(8'h81, 0, 1'b0, 1'b1, t0);
    expect_ev("after_break", 0, mk(t0 + 98, 1, 0, 0, 0, 8'h81));
    expect_none("after_break_extra", 0);
    bitw(1'b1, 10);

    bitw(1'b0, CPB);
    bitw(1'b1, CPB);
    bitw(1'b0, 5);
    reset_ni = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outs", {dat[0], v[0], fe[0], pe[0], br[0]}, 32'h0);
    repeat (4) @(negedge clk);
    reset_ni = 1'b1;
    bitw(1'b0, 20);
    expect_none("reset_low_line", 0);
    bitw(1'b1, 20);
    expect_none("reset_idle", 0);
    send(8'hFF, 0, 1'b0, 1'b1, t0);
    expect_ev("after_reset", 0, mk(t0 + 98, 1, 0, 0, 0, 8'hFF));
    expect_none("after_reset_extra", 0);
    bitw(1'b1, 5);
    last0 = 8'hFF;

    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      logic stop;
      int gap;
      d = 8'($urandom);
      if (k % 7 == 3) d = 8'h00;
      stop = ($urandom_range(0, 4) != 0);
      gap = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 12));
      send(d, 0, 1'b0, stop, t0);
      x = model(0, d, 1'b0, stop, last0, t0 + 98);
      expect_ev($sformatf("rnd0_%0d", k), 0, x);
      expect_none($sformatf("rnd0_%0d_extra", k), 0);
      if (x.v) last0 = d;
      bitw(1'b1, gap);
    end

    do_reset();
    send(8'h07, 1, 1'b1, 1'b1, t0);
    expect_ev("p_even_ok", 1, mk(t0 + 108, 1, 0, 0, 0, 8'h07));
    expect_ev("p_odd_bad", 2, mk(t0 + 108, 0, 0, 1, 0, 8'h00));
    expect_none("p_a_extra1", 1);
    expect_none("p_a_extra2", 2);
    bitw(1'b1, 4);
    send(8'h07, 1, 1'b0, 1'b1, t0);
    expect_ev("p_even_bad", 1, mk(t0 + 108, 0, 0, 1, 0, 8'h07));
    expect_ev("p_odd_ok", 2, mk(t0 + 108, 1, 0, 0, 0, 8'h07));
    expect_none("p_b_extra1", 1);
    expect_none("p_b_extra2", 2);
    chk("p_even_hold", dat[1], 8'h07);
    bitw(1'b1, 4);
    last1 = 8'h07;
    last2 = 8'h07;

    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      logic p, stop;
      int gap;
      d = 8'($urandom);
      if (k % 8 == 5) d = 8'h00;
      p = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 12));
      send(d, 1, p, stop, t0);
      x = model(1, d, p, stop, last1, t0 + 108);
      expect_ev($sformatf("rnd1_%0d", k), 1, x);
      if (x.v) last1 = d;
      x = model(2, d, p, stop, last2, t0 + 108);
      expect_ev($sformatf("rnd2_%0d", k), 2, x);
      if (x.v) last2 = d;
      expect_none($sformatf("rnd1_%0d_extra", k), 1);
      expect_none($sformatf("rnd2_%0d_extra", k), 2);
      bitw(1'b1, gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
